dmem_dump_arbiter: RTL

Owns the single data-memory port in the MEM stage and shares it between the pipeline (MEM-stage load/store flags) and the debug unit's memory-dump engine. On a dump request it stalls the pipeline, walks the data memory word by word, and streams each word to the debug unit over a valid/ready handshake. When no dump is active it is a transparent pass-through of the pipeline's access.

---
 rtl/dmem_dump_arbiter_pkg.sv | 22 ++
 rtl/dmem_dump_arbiter_dump_addr_counter.sv | 45 ++++
 rtl/dmem_dump_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dmem_dump_arbiter_pkg.sv
// Shared definitions for the data-memory dump arbiter: FSM state encoding,
// default geometry of the dump, and the index-width helper.
package dmem_dump_arbiter_pkg;

  localparam int DEF_MSB       = 31;
  localparam int DEF_N_WORDS   = 32;
  localparam int DEF_ADDR_STEP = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_e;

  // A single-word dump still needs a one-bit index register.
  function automatic int idx_width(input int n_words);
    return (n_words > 1) ? $clog2(n_words) : 1;
  endfunction

endpackage

// File: rtl/dmem_dump_arbiter_dump_addr_counter.sv
// Word index for the memory dump: clear at dump start, step after each
// accepted word, flag the final word, and present the byte address.
module dump_addr_counter
  import dmem_dump_arbiter_pkg::*;
#(
  parameter int msb       = DEF_MSB,
  parameter int N_WORDS   = DEF_N_WORDS,
  parameter int ADDR_STEP = DEF_ADDR_STEP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         incr_i,
  output logic         last_o,
  output logic [msb:0] addr_o
);

  localparam int IDX_W = idx_width(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // The terminal compare gates the increment, so the index never wraps.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (incr_i && !last_o) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign last_o = (idx_q == LAST_IDX);
  assign addr_o = (msb+1)'(idx_q) * (msb+1)'(ADDR_STEP);

endmodule

// File: rtl/dmem_dump_arbiter.sv
// MEM-stage data-memory port owner: passes the pipeline access through when
// idle, and on request stalls the pipeline and streams memory to the debug unit.
module dmem_dump_arbiter
  import dmem_dump_arbiter_pkg::*;
#(
  parameter int msb       = DEF_MSB,
  parameter int N_WORDS   = DEF_N_WORDS,
  parameter int ADDR_STEP = DEF_ADDR_STEP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_pipe_rd,
  input  logic         in_pipe_wr,
  input  logic [msb:0] in_pipe_addr,
  input  logic [msb:0] in_pipe_wdata,
  input  logic         in_dump_start,
  input  logic         in_tx_ready,
  input  logic [msb:0] in_mem_rdata,
  output logic         out_mem_rd,
  output logic         out_mem_wr,
  output logic [msb:0] out_mem_addr,
  output logic [msb:0] out_mem_wdata,
  output logic         out_pipe_stall,
  output logic [msb:0] out_tx_data,
  output logic         out_tx_valid,
  output logic         out_dump_busy,
  output logic         out_dump_done
);

  dump_state_e  state_q;
  logic [msb:0] tx_data_q;
  logic         tx_valid_q;
  logic         done_q;
  logic         busy_q;

  logic         cnt_clear;
  logic         cnt_incr;
  logic         dump_last;
  logic [msb:0] dump_addr;

  assign cnt_clear = (state_q == ST_IDLE) && in_dump_start;
  assign cnt_incr  = (state_q == ST_SEND) && in_tx_ready;

  dump_addr_counter #(
    .msb       (msb),
    .N_WORDS   (N_WORDS),
    .ADDR_STEP (ADDR_STEP)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .incr_i  (cnt_incr),
    .last_o  (dump_last),
    .addr_o  (dump_addr)
  );

  // Status outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_dump_start) begin
            state_q <= ST_READ;
            busy_q  <= 1'b1;
          end
        end
        ST_READ: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          tx_data_q  <= in_mem_rdata;
          tx_valid_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (in_tx_ready) begin
            tx_valid_q <= 1'b0;
            if (dump_last) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Only IDLE lets the pipeline through; every dump state blocks its writes.
  always_comb begin
    out_mem_rd    = 1'b0;
    out_mem_wr    = 1'b0;
    out_mem_addr  = dump_addr;
    out_mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        out_mem_rd    = in_pipe_rd;
        out_mem_wr    = in_pipe_wr;
        out_mem_addr  = in_pipe_addr;
        out_mem_wdata = in_pipe_wdata;
      end
      ST_READ: begin
        out_mem_rd = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign out_pipe_stall = busy_q;
  assign out_dump_busy  = busy_q;
  assign out_tx_data    = tx_data_q;
  assign out_tx_valid   = tx_valid_q;
  assign out_dump_done  = done_q;

endmodule
